// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin instruction memory arbiter, fetch vs debug, with halt handshake
// Response data is steered from mem_rdata by select bits registered at grant time.
module imem_arbiter #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_WORD  = 32'h0010_0000,
  parameter logic [ADDR_W-1:0]  LIMIT_WORD = 32'h0010_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  input  logic              d_halt,
  output logic              d_halt_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_f_rvalid, r_f_err, r_f_rd;
  logic                r_d_rvalid, r_d_err, r_d_rd;
  logic                w_f_allow, w_f_elig, w_d_elig;
  logic                w_f_gnt, w_d_gnt, w_err, w_mem_en;
  logic [ADDR_W-1:0]   w_addr, w_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:    if (d_halt) w_next = S_DRAIN;
      S_DRAIN:  if (!d_halt) w_next = S_RUN;
                else if (!w_f_gnt) w_next = S_HALTED;
      S_HALTED: if (!d_halt) w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  // Fetch is cut off in the same cycle d_halt is first seen.
  always_comb begin
    w_f_allow  = (r_state == S_RUN) && !d_halt;
    d_halt_ack = (r_state == S_HALTED);
  end

  // r_last_d=1 means debug won last, so fetch wins the next tie.
  always_comb begin
    w_f_elig = f_req & w_f_allow & ~reset;
    w_d_elig = d_req & ~reset;
    w_f_gnt  = w_f_elig & (~w_d_elig | r_last_d);
    w_d_gnt  = w_d_elig & ~w_f_gnt;
    w_addr   = w_d_gnt ? d_addr : f_addr;
    w_word   = w_addr >> 2;
    w_err    = (w_addr[1:0] != 2'b00) || (w_word < BASE_WORD) || (w_word > LIMIT_WORD);
    w_mem_en = (w_f_gnt | w_d_gnt) & ~w_err;
  end

  assign f_gnt     = w_f_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_en & w_d_gnt & d_we;
  assign mem_addr  = w_mem_en ? w_word : '0;
  assign mem_wdata = (w_mem_en & w_d_gnt) ? d_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d   <= 1'b1;
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_f_rd     <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rd     <= 1'b0;
    end else begin
      if (w_f_gnt | w_d_gnt) r_last_d <= w_d_gnt;
      r_f_rvalid <= w_f_gnt;
      r_f_err    <= w_f_gnt & w_err;
      r_f_rd     <= w_f_gnt & ~w_err;
      r_d_rvalid <= w_d_gnt;
      r_d_err    <= w_d_gnt & w_err;
      r_d_rd     <= w_d_gnt & ~w_err & ~d_we;
    end
  end

  assign f_rvalid = r_f_rvalid;
  assign f_err    = r_f_err;
  assign f_rdata  = r_f_rd ? mem_rdata : '0;
  assign d_rvalid = r_d_rvalid;
  assign d_err    = r_d_err;
  assign d_rdata  = r_d_rd ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err, d_halt, d_halt_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  int checks = 0;
  int failures = 0;

  imem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .d_halt(d_halt), .d_halt_ack(d_halt_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: a read of word index i returns i+1 one cycle later.
  always @(posedge clk) if (mem_en) mem_rdata <= mem_we ? 32'h0 : mem_addr + 32'h1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    f_addr = 32'h0040_0000; d_addr = 32'h0040_0004; d_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt, mem_en, mem_we, f_rvalid, f_err, d_rvalid, d_err, d_halt_ack} !== 9'b0) begin
      failures++; $display("FAIL reset_ctrl got %b exp 0", {f_gnt, d_gnt, mem_en, mem_we, f_rvalid, f_err, d_rvalid, d_err, d_halt_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got %h %h %h %h exp 0", mem_addr, mem_wdata, f_rdata, d_rdata);
    end
    step(); f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g, prev_g;
    logic [31:0] exp_a, prev_d;
    prev_g = 2'b00; prev_d = 32'h0;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = 32'h0040_0000; d_addr = 32'h0040_0008;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 0) ? 32'h0010_0000 : 32'h0010_0002;
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== exp_g || mem_addr !== exp_a || mem_en !== 1'b1) begin
        failures++; $display("FAIL rr_gnt c%0d got %b/%h exp %b/%h", k, {f_gnt, d_gnt}, mem_addr, exp_g, exp_a);
      end
      if (k > 0) begin
        checks++;
        if ({f_rvalid, d_rvalid} !== prev_g || (prev_g[1] ? f_rdata : d_rdata) !== prev_d) begin
          failures++; $display("FAIL rr_resp c%0d got %b f=%h d=%h exp %b %h", k, {f_rvalid, d_rvalid}, f_rdata, d_rdata, prev_g, prev_d);
        end
      end
      prev_g = exp_g; prev_d = exp_a + 32'h1;
      step();
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'h0010_0003) begin
      failures++; $display("FAIL rr_last got %b %h exp 01 00100003", {f_rvalid, d_rvalid}, d_rdata);
    end
  endtask

  task automatic test_fetch_stream();
    step(); f_req = 1'b1; f_addr = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h0010_0000) begin
        failures++; $display("FAIL fetch_gnt c%0d got %b %h exp 1010 00100000", i, {f_gnt, d_gnt, mem_en, mem_we}, mem_addr);
      end
      if (i > 0) begin
        checks++;
        if ({f_rvalid, f_err, d_rvalid} !== 3'b100 || f_rdata !== 32'h0010_0001) begin
          failures++; $display("FAIL fetch_resp c%0d got %b %h exp 100 00100001", i, {f_rvalid, f_err, d_rvalid}, f_rdata);
        end
      end
      step();
    end
    f_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_gnt, f_rvalid} !== 2'b01 || f_rdata !== 32'h0010_0001) begin
      failures++; $display("FAIL fetch_tail got %b %h exp 01 00100001", {f_gnt, f_rvalid}, f_rdata);
    end
  endtask

  task automatic test_debug_write();
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0040_0004; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h0010_0001 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL dwr_issue got %b %h %h exp 111 00100001 deadbeef", {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    step(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL dwr_ack got %b %h exp 10 0", {d_rvalid, d_err}, d_rdata);
    end
  endtask

  task automatic test_errors();
    step(); f_req = 1'b1; f_addr = 32'h0040_0002;
    @(negedge clk);
    checks++;
    if ({f_gnt, mem_en} !== 2'b10) begin
      failures++; $display("FAIL mis_issue got %b exp 10", {f_gnt, mem_en});
    end
    step(); f_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_rvalid, f_err} !== 2'b11 || f_rdata !== 32'h0) begin
      failures++; $display("FAIL mis_resp got %b %h exp 11 0", {f_rvalid, f_err}, f_rdata);
    end
    step(); d_req = 1'b1; d_addr = 32'h0040_4004;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_en} !== 2'b10) begin
      failures++; $display("FAIL lim1_issue got %b exp 10", {d_gnt, mem_en});
    end
    step(); d_addr = 32'h0040_4000;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin
      failures++; $display("FAIL lim1_resp got %b %h exp 11 0", {d_rvalid, d_err}, d_rdata);
    end
    checks++;
    if ({d_gnt, mem_en} !== 2'b11 || mem_addr !== 32'h0010_1000) begin
      failures++; $display("FAIL lim_issue got %b %h exp 11 00101000", {d_gnt, mem_en}, mem_addr);
    end
    step(); d_addr = 32'h003F_FFFC;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h0010_1001) begin
      failures++; $display("FAIL lim_resp got %b %h exp 10 00101001", {d_rvalid, d_err}, d_rdata);
    end
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_err} !== 2'b11) begin
      failures++; $display("FAIL base_resp got %b exp 11", {d_rvalid, d_err});
    end
  endtask

  task automatic test_halt();
    step(); f_req = 1'b1; f_addr = 32'h0040_0000;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1) begin failures++; $display("FAIL halt_c0 got %b exp 1", f_gnt); end
    step(); d_halt = 1'b1;
    @(negedge clk);
    checks++;
    if ({f_gnt, f_rvalid, d_halt_ack} !== 3'b010 || f_rdata !== 32'h0010_0001) begin
      failures++; $display("FAIL halt_c1 got %b %h exp 010 00100001", {f_gnt, f_rvalid, d_halt_ack}, f_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({f_gnt, f_rvalid, d_halt_ack} !== 3'b000) begin
      failures++; $display("FAIL halt_c2 got %b exp 000", {f_gnt, f_rvalid, d_halt_ack});
    end
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0040_0008;
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt, d_halt_ack} !== 3'b011) begin
      failures++; $display("FAIL halt_c3 got %b exp 011", {f_gnt, d_gnt, d_halt_ack});
    end
    step(); d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_halt_ack} !== 2'b11 || d_rdata !== 32'h0010_0003) begin
      failures++; $display("FAIL halt_c4 got %b %h exp 11 00100003", {d_rvalid, d_halt_ack}, d_rdata);
    end
    step(); d_halt = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_gnt, d_halt_ack} !== 2'b01) begin
      failures++; $display("FAIL halt_c5 got %b exp 01", {f_gnt, d_halt_ack});
    end
    step();
    @(negedge clk);
    checks++;
    if ({f_gnt, d_halt_ack} !== 2'b10 || mem_addr !== 32'h0010_0000) begin
      failures++; $display("FAIL halt_c6 got %b %h exp 10 00100000", {f_gnt, d_halt_ack}, mem_addr);
    end
    step(); f_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    step(); f_req = 1'b1; f_addr = 32'h0040_0000;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1) begin failures++; $display("FAIL rst_pre got %b exp 1", f_gnt); end
    step(); reset = 1'b1; f_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_rvalid, f_err, d_rvalid, d_err, d_halt_ack, mem_en} !== 6'b0 || f_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_drop got %b %h exp 0", {f_rvalid, f_err, d_rvalid, d_err, d_halt_ack, mem_en}, f_rdata);
    end
    step(); f_req = 1'b1; d_req = 1'b1; d_addr = 32'h0040_0008;
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin
      failures++; $display("FAIL rst_hold got %b exp 000", {f_gnt, d_gnt, mem_en});
    end
    step(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL rst_tie got %b exp 10", {f_gnt, d_gnt});
    end
    step(); f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_rvalid, d_rvalid} !== 2'b10 || f_rdata !== 32'h0010_0001) begin
      failures++; $display("FAIL rst_resp got %b %h exp 10 00100001", {f_rvalid, d_rvalid}, f_rdata);
    end
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_halt = 1'b0;
    f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    test_reset();
    test_round_robin();
    test_fetch_stream();
    test_debug_write();
    test_errors();
    test_halt();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
